// File: rtl/bus_arbiter_if.sv
// Bus arbitration interface: masters drive requests, the arbiter returns the grant.
// The wired slave-busy line travels here too so the arbiter sees all bus activity.
interface bus_arbiter_if #(
    parameter int NUM_MASTERS    = 4,
    parameter int GRANT_ID_WIDTH = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0]    mreq;
    logic                      slave_busy;
    logic [NUM_MASTERS-1:0]    mgrant;
    logic [GRANT_ID_WIDTH-1:0] grant_id;
    logic                      bus_busy;
    logic                      timeout;

    // Requester side: drives requests and the slave-busy line.
    modport master (
        output mreq, slave_busy,
        input  mgrant, grant_id, bus_busy, timeout
    );

    // Arbiter side.
    modport slave (
        input  mreq, slave_busy,
        output mgrant, grant_id, bus_busy, timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a dead cycle between owners and idle-timeout revocation.
// All outputs are registered; inputs are sampled only on the rising clock edge.
module bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GRANT_ID_WIDTH = $clog2(NUM_MASTERS)
) (
    input  logic         clk,
    input  logic         rstn,
    bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e                    state_q;
    logic [NUM_MASTERS-1:0]    mgrant_q;
    logic [GRANT_ID_WIDTH-1:0] grant_id_q;
    logic [GRANT_ID_WIDTH-1:0] last_ptr_q;
    logic                      bus_busy_q;
    logic                      timeout_q;
    logic [7:0]                idle_cnt_q;

    logic                      winner_found;
    logic [GRANT_ID_WIDTH-1:0] winner_id_d;
    logic [GRANT_ID_WIDTH-1:0] cand;
    logic [NUM_MASTERS-1:0]    grant_d;

    // Search starts one past the last owner, so the last owner is considered last.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        winner_found = 1'b0;
        winner_id_d  = last_ptr_q;
        cand         = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = GRANT_ID_WIDTH'((int'(last_ptr_q) + k) % NUM_MASTERS);
            if (!winner_found && bus.mreq[cand]) begin
                winner_found = 1'b1;
                winner_id_d  = cand;
            end
        end
        grant_d = NUM_MASTERS'(1) << winner_id_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            mgrant_q   <= '0;
            grant_id_q <= '0;
            last_ptr_q <= GRANT_ID_WIDTH'(NUM_MASTERS - 1);
            bus_busy_q <= 1'b0;
            timeout_q  <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (!bus.slave_busy && winner_found) begin
                        mgrant_q   <= grant_d;
                        grant_id_q <= winner_id_d;
                        last_ptr_q <= winner_id_d;
                        bus_busy_q <= 1'b1;
                        idle_cnt_q <= '0;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    // A release by the owner wins over a timeout on the same edge.
                    if (!bus.mreq[grant_id_q]) begin
                        mgrant_q   <= '0;
                        bus_busy_q <= 1'b0;
                        state_q    <= RELEASE;
                    end else if (bus.slave_busy) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == TIMEOUT_LAST) begin
                        mgrant_q   <= '0;
                        bus_busy_q <= 1'b0;
                        timeout_q  <= 1'b1;
                        state_q    <= RELEASE;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 8'd1;
                    end
                end
                RELEASE: begin
                    timeout_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    mgrant_q   <= '0;
                    bus_busy_q <= 1'b0;
                    timeout_q  <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.mgrant   = mgrant_q;
    assign bus.grant_id = grant_id_q;
    assign bus.bus_busy = bus_busy_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: round-robin order, dead-cycle gaps, timeout,
// slave-busy blocking/extension, release-over-timeout priority and mid-grant reset.
module tb_bus_arbiter;

    localparam int NM = 4;
    localparam int TO = 8;

    logic clk;
    logic rstn;
    int   n_checks = 0;
    int   n_fails  = 0;

    bus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

    bus_arbiter #(
        .NUM_MASTERS   (NM),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected grant, held grant_id and timeout; bus_busy must mirror the grant.
    task automatic expect_out(input string tag, input logic [NM-1:0] g,
                              input logic [1:0] id, input logic to);
        check({tag, ".mgrant"},   32'(bus.mgrant),   32'(g));
        check({tag, ".grant_id"}, 32'(bus.grant_id), 32'(id));
        check({tag, ".bus_busy"}, 32'(bus.bus_busy), 32'(|g));
        check({tag, ".timeout"},  32'(bus.timeout),  32'(to));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drop the owner's request and expect two zero cycles, then the next owner.
    task automatic handover(input string tag, input logic [NM-1:0] new_req,
                            input logic [1:0] old_id, input logic [NM-1:0] next_g,
                            input logic [1:0] next_id);
        bus.mreq = new_req;
        step();
        expect_out({tag, ".gap1"}, '0, old_id, 1'b0);
        step();
        expect_out({tag, ".gap2"}, '0, old_id, 1'b0);
        step();
        expect_out({tag, ".next"}, next_g, next_id, 1'b0);
    endtask

    initial begin
        rstn           = 1'b0;
        bus.mreq       = '0;
        bus.slave_busy = 1'b0;
        #1;
        expect_out("reset", '0, 2'd0, 1'b0);
        step();
        step();
        rstn = 1'b1;
        step();
        expect_out("post_reset", '0, 2'd0, 1'b0);

        // First arbitration after reset, then rotation 0 -> 1 -> 2 -> 3.
        bus.mreq = 4'b1111;
        step();
        expect_out("first_grant", 4'b0001, 2'd0, 1'b0);
        handover("rr_1", 4'b1110, 2'd0, 4'b0010, 2'd1);
        handover("rr_2", 4'b1100, 2'd1, 4'b0100, 2'd2);
        handover("rr_3", 4'b1000, 2'd2, 4'b1000, 2'd3);
        bus.mreq = '0;
        step();
        step();
        expect_out("rr_idle", '0, 2'd3, 1'b0);

        // Fairness: with master 2 last owner, 0101 serves 0 before 2.
        bus.mreq = 4'b0100;
        step();
        expect_out("fair_setup", 4'b0100, 2'd2, 1'b0);
        bus.mreq = '0;
        step();
        step();
        bus.mreq = 4'b0101;
        step();
        expect_out("fair_0_first", 4'b0001, 2'd0, 1'b0);
        handover("fair_then_2", 4'b0100, 2'd0, 4'b0100, 2'd2);
        bus.mreq = '0;
        step();
        step();

        // Timeout: master 1 holds without slave activity for exactly TO cycles.
        bus.mreq = 4'b0010;
        step();
        expect_out("to_grant", 4'b0010, 2'd1, 1'b0);
        bus.mreq = 4'b1010;
        for (int i = 2; i <= TO; i++) begin
            step();
            expect_out($sformatf("to_hold%0d", i), 4'b0010, 2'd1, 1'b0);
        end
        step();
        expect_out("to_pulse", '0, 2'd1, 1'b1);
        step();
        expect_out("to_pulse_end", '0, 2'd1, 1'b0);
        step();
        expect_out("to_next_3", 4'b1000, 2'd3, 1'b0);
        bus.mreq = '0;
        step();
        step();

        // Slave activity keeps the grant alive; timeout counts from the falling edge.
        bus.mreq = 4'b0001;
        step();
        expect_out("sb_grant", 4'b0001, 2'd0, 1'b0);
        bus.slave_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            expect_out($sformatf("sb_busy%0d", i), 4'b0001, 2'd0, 1'b0);
        end
        bus.slave_busy = 1'b0;
        for (int i = 1; i < TO; i++) begin
            step();
            expect_out($sformatf("sb_idle%0d", i), 4'b0001, 2'd0, 1'b0);
        end
        step();
        expect_out("sb_timeout", '0, 2'd0, 1'b1);
        bus.mreq = '0;
        step();
        step();

        // Busy line blocks arbitration in IDLE.
        bus.slave_busy = 1'b1;
        bus.mreq       = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("block%0d", i), '0, 2'd0, 1'b0);
        end
        bus.slave_busy = 1'b0;
        step();
        expect_out("unblock", 4'b0010, 2'd1, 1'b0);

        // Release lands on the edge where timeout would fire: no pulse.
        for (int i = 2; i <= TO; i++) step();
        expect_out("sim_before", 4'b0010, 2'd1, 1'b0);
        bus.mreq = 4'b0100;
        step();
        expect_out("sim_release", '0, 2'd1, 1'b0);
        step();
        expect_out("sim_gap", '0, 2'd1, 1'b0);
        step();
        expect_out("sim_next_2", 4'b0100, 2'd2, 1'b0);

        // Asynchronous reset in the middle of a grant.
        #2;
        rstn = 1'b0;
        #1;
        expect_out("midrst", '0, 2'd0, 1'b0);
        step();
        expect_out("midrst_held", '0, 2'd0, 1'b0);
        bus.mreq = 4'b1111;
        rstn     = 1'b1;
        step();
        expect_out("midrst_first", 4'b0001, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
